// File: rtl/ram_rd_pkg.sv
// rtl/ram_rd_pkg.sv - shared types and constants for the RAM stream reader
// Contents: rd_state_t (reader FSM states), BUF_DEPTH (output buffer depth).
package ram_rd_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN} rd_state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/ram_sp.sv
// rtl/ram_sp.sv - single-port synchronous RAM, registered address, 1-cycle read latency
// Ports:
//   i_clk          clock
//   i_we           write enable
//   i_addr, i_d    address and write data
//   o_q            word at the address sampled on the previous edge
module ram_sp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_d;
    end
    o_q <= r_mem[i_addr];
  end

endmodule

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - 2-entry FIFO that hides the RAM read latency
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_push, i_data      write strobe and word
//   i_pop               read strobe (only while not empty)
//   o_data              head word (0 after reset)
//   o_full, o_empty     occupancy flags
//   o_count             number of stored words, 0..2
module stream_fifo2
  import ram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [1:0]            o_count
);

  localparam logic [1:0] LP_FULL = 2'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == LP_FULL);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - reads a contiguous RAM range and streams it out in order
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_start                   transfer request, honoured only in IDLE
//   i_base_addr, i_length     first address and word count (0..2**ADDR_WIDTH)
//   o_busy, o_done            transfer in progress / 1-cycle completion pulse
//   o_ram_addr, o_ram_we      RAM address (held when idle), write enable (always 0)
//   i_ram_q                   RAM read data, one cycle after the address
//   o_out_data, o_out_valid   stream word and valid
//   o_out_last                marks the final word
//   i_out_ready               consumer ready
module ram_stream_reader
  import ram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_q,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_valid,
  output logic                  o_out_last,
  input  logic                  i_out_ready
);

  rd_state_t             r_state;
  rd_state_t             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_issued;
  logic [ADDR_WIDTH:0]   r_popped;
  logic                  r_inflight;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [2:0]            w_occ;
  logic                  w_full;
  logic                  w_empty;
  logic [1:0]            w_count;

  stream_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (i_ram_q),
    .i_pop   (w_pop),
    .o_data  (o_out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // The issue rule already keeps the buffer from overflowing; the full
  // gate only makes the buffer safe on its own.
  assign w_push = r_inflight & ~w_full;
  assign w_pop  = o_out_valid & i_out_ready;
  assign w_occ  = {1'b0, w_count} + {2'b00, r_inflight};

  always_comb begin
    w_issue     = 1'b0;
    w_state_nxt = r_state;
    // Count the word already in flight so a slot is reserved for it;
    // a pop this cycle frees one slot.
    if (r_state == RUN && r_issued < r_len && w_occ < (3'd2 + {2'b00, w_pop})) begin
      w_issue = 1'b1;
    end
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_length == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        // Leave as the final word is taken, so done follows it directly.
        if (r_issued == r_len && !r_inflight &&
            (w_empty || (w_count == 2'd1 && w_pop))) begin
          w_state_nxt = FIN;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_addr_hold <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_popped    <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (r_state == IDLE && i_start) begin
        r_ptr    <= i_base_addr;
        r_len    <= i_length;
        r_issued <= '0;
        r_popped <= '0;
      end
      if (w_issue) begin
        r_ptr       <= r_ptr + 1'b1;
        r_issued    <= r_issued + 1'b1;
        r_addr_hold <= r_ptr;
      end
      if (w_pop) begin
        r_popped <= r_popped + 1'b1;
      end
    end
  end

  // The RAM registers its address, so the pointer goes out combinationally
  // on an issue cycle and the data comes back while r_inflight is set.
  assign o_ram_addr  = w_issue ? r_ptr : r_addr_hold;
  assign o_ram_we    = 1'b0;
  assign o_out_valid = ~w_empty;
  assign o_out_last  = o_out_valid && (r_popped == r_len - {{ADDR_WIDTH{1'b0}}, 1'b1});
  assign o_busy      = (r_state == RUN);
  assign o_done      = (r_state == FIN);

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - scoreboard bench for ram_stream_reader on a real RAM
module tb_ram_stream_reader;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;

  logic          init_mode;
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_d;

  always #5 clk = ~clk;

  ram_sp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_ram (
    .i_clk  (clk),
    .i_we   (init_mode ? tb_we : ram_we),
    .i_addr (init_mode ? tb_addr : ram_addr),
    .i_d    (tb_d),
    .o_q    (ram_q)
  );

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_length    (length),
    .o_busy      (busy),
    .o_done      (done),
    .o_ram_addr  (ram_addr),
    .o_ram_we    (ram_we),
    .i_ram_q     (ram_q),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .o_out_last  (out_last),
    .i_out_ready (out_ready)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t       sb[$];
  int         beat_cyc[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         beats = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         valid_cycles = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  bit [0:5]   pat = 6'b100101;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (out_valid) valid_cycles++;
      if (prev_stall) check("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
      if (out_valid && out_ready) begin
        beats++;
        beat_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data 0x%0h with nothing expected", out_data);
        end else begin
          e = sb.pop_front();
          check("beat_data", {24'd0, out_data}, {24'd0, e.d});
          check("beat_last", {31'd0, out_last}, {31'd0, e.l});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic load(input int b, input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.d = 8'hA0 + 8'((b + i) & 15);
      e.l = (i == len - 1);
      sb.push_back(e);
    end
  endtask

  task automatic clear_stats();
    done_cnt = 0;
    beats    = 0;
    beat_cyc.delete();
  endtask

  task automatic pulse_start(input int b, input int len, output int sc);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(b);
    length    = (AW + 1)'(len);
    @(posedge clk);
    #1;
    sc    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int mode, input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(posedge clk);
      #1;
      if (mode == 0) out_ready = 1'b1;
      else if (n < 6) out_ready = pat[n];
      else out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check({name, "_done_seen"}, done_cnt, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    check({name, "_done_once"}, done_cnt, 1);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    int sc;
    int n;
    int vc;
    logic [AW-1:0] addr0;

    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b1;
    init_mode = 1'b1;
    tb_we     = 1'b0;
    tb_addr   = '0;
    tb_d      = '0;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      tb_we   = 1'b1;
      tb_addr = AW'(i);
      tb_d    = 8'hA0 + 8'(i);
    end
    @(posedge clk);
    #1;
    tb_we     = 1'b0;
    init_mode = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_outputs", {18'd0, busy, done, out_valid, out_last, ram_we, ram_addr, out_data}, 32'd0);

    // 1: base 2, length 4, full throughput
    clear_stats();
    load(2, 4);
    pulse_start(2, 4, sc);
    wait_done(0, "t1");
    check("t1_beats", beats, 4);
    if (beat_cyc.size() == 4) begin
      check("t1_first_latency", beat_cyc[0] - sc, 2);
      check("t1_back_to_back", beat_cyc[3] - beat_cyc[0], 3);
      check("t1_done_after_last", done_cyc - beat_cyc[3], 1);
    end

    // 2: wrap past the top of the RAM
    clear_stats();
    load(14, 4);
    pulse_start(14, 4, sc);
    wait_done(0, "t2");
    check("t2_beats", beats, 4);

    // 3: backpressure
    clear_stats();
    load(0, 6);
    pulse_start(0, 6, sc);
    wait_done(1, "t3");
    check("t3_beats", beats, 6);

    // 4: zero length
    clear_stats();
    addr0 = ram_addr;
    vc    = valid_cycles;
    pulse_start(5, 0, sc);
    wait_done(0, "t4");
    check("t4_no_valid", valid_cycles - vc, 0);
    check("t4_no_read", {28'd0, ram_addr}, {28'd0, addr0});
    check("t4_done_latency", {31'd0, (done_cyc - sc) <= 1}, 32'd1);

    // 5: reset mid-transfer, then a fresh transfer
    clear_stats();
    load(0, 16);
    pulse_start(0, 16, sc);
    n = 0;
    while (beats < 5 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_reached_5_beats", {31'd0, beats >= 5}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    check("t5_reset_outputs", {18'd0, busy, done, out_valid, out_last, ram_we, ram_addr, out_data}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt, 0);
    clear_stats();
    load(1, 2);
    pulse_start(1, 2, sc);
    wait_done(0, "t5b");
    check("t5b_beats", beats, 2);

    // 6: start while busy is ignored
    clear_stats();
    load(3, 5);
    pulse_start(3, 5, sc);
    repeat (2) @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 4'd9;
    length    = 5'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0, "t6");
    check("t6_beats", beats, 5);

    repeat (5) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
